// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: instruction memory, hazard controls, IF/ID outputs
//
// Purpose: bundles every fetch_unit signal except clk/rst.
// Ports (master = fetch_unit side):
//   pc_out          out 32  current PC, drives instruction-memory address
//   instr_in        in  32  instruction read asynchronously at pc_out
//   stall           in  1   hold PC and IF/ID
//   flush           in  1   replace IF/ID contents with a bubble
//   redirect        in  1   taken branch or jump
//   redirect_pc     in  32  redirect target, bits [1:0] ignored
//   if_id_instr     out 32  registered instruction
//   if_id_pc4       out 32  registered PC+4 of that instruction
//   if_id_valid     out 1   IF/ID holds a real instruction
//   perf_fetch_cnt  out 32  valid instructions loaded into IF/ID
//   perf_stall_cnt  out 32  stalled cycles
interface fetch_unit_if;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    modport master (
        output pc_out,
        input  instr_in,
        input  stall,
        input  flush,
        input  redirect,
        input  redirect_pc,
        output if_id_instr,
        output if_id_pc4,
        output if_id_valid,
        output perf_fetch_cnt,
        output perf_stall_cnt
    );

    modport slave (
        input  pc_out,
        output instr_in,
        output stall,
        output flush,
        output redirect,
        output redirect_pc,
        input  if_id_instr,
        input  if_id_pc4,
        input  if_id_valid,
        input  perf_fetch_cnt,
        input  perf_stall_cnt
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction-fetch stage: PC register and IF/ID pipeline register
//
// Purpose: holds the PC, presents it to an asynchronous instruction memory,
// captures the returned instruction into IF/ID and handles stall, flush and
// branch/jump redirect.
// Parameters:
//   RESET_PC  PC value loaded on reset
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous reset, active-high
//   bus  fetch_unit_if.master (see rtl/fetch_unit_if.sv)
// Optional feature: define FETCH_PERF_EN to build the fetch/stall performance
// counters; otherwise both perf outputs are tied to zero.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic [31:0] if_id_instr_q;
    logic [31:0] if_id_pc4_q;
    logic        if_id_valid_q;
    logic        unused_ok;

    assign pc_inc = pc + 32'd4;

    assign bus.pc_out      = pc;
    assign bus.if_id_instr = if_id_instr_q;
    assign bus.if_id_pc4   = if_id_pc4_q;
    assign bus.if_id_valid = if_id_valid_q;

    // Targets are word aligned; the low bits of redirect_pc carry no meaning.
    assign unused_ok = ^bus.redirect_pc[1:0];

    // Redirect wins over stall so a taken branch is never lost to a hazard hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (bus.redirect) begin
            pc <= {bus.redirect_pc[31:2], 2'b00};
        end else if (!bus.stall) begin
            pc <= pc_inc;
        end
    end

    // A redirect drops the wrong-path instruction fetched this cycle. flush with
    // stall clears IF/ID while the PC holds, so the held word is refetched.
    always_ff @(posedge clk) begin
        if (rst || bus.flush || bus.redirect) begin
            if_id_instr_q <= 32'd0;
            if_id_pc4_q   <= 32'd0;
            if_id_valid_q <= 1'b0;
        end else if (!bus.stall) begin
            if_id_instr_q <= bus.instr_in;
            if_id_pc4_q   <= pc_inc;
            if_id_valid_q <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (!bus.flush && !bus.redirect && !bus.stall) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (bus.stall && !bus.redirect && !bus.flush) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign bus.perf_fetch_cnt = fetch_cnt;
    assign bus.perf_stall_cnt = stall_cnt;
`else
    assign bus.perf_fetch_cnt = 32'd0;
    assign bus.perf_stall_cnt = 32'd0;
`endif

endmodule
